paddle_ctrl: RTL and testbench

// Paddle (bar) controller for Breakout: turns the left/right push-buttons into the
// bar centre position (x_bar, y_bar) consumed by the ball/collision block. It

---
 rtl/paddle_ctrl.sv | 149 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Breakout paddle controller: synchronises and debounces the two buttons, moves
// the bar on a fixed tick with hold acceleration, clamps it to the screen, and
// tracks the IDLE/PLAY/OVER game state from start and endgame.
module paddle_ctrl #(
  parameter int unsigned H_BAR       = 8,
  parameter int unsigned W_BAR       = 64,
  parameter int unsigned X_INIT      = 320,
  parameter int unsigned Y_BAR       = 440,
  parameter int unsigned TICK_DIV    = 250000,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned STEP_SLOW   = 2,
  parameter int unsigned STEP_FAST   = 6,
  parameter int unsigned ACCEL_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start,
  input  logic       endgame,
  output logic [9:0] x_bar,
  output logic [9:0] y_bar,
  output logic       playing
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [10:0] LIM_LEFT  = 11'(W_BAR);
  localparam logic [10:0] LIM_RIGHT = 11'(640 - W_BAR);

  // The bar must lie entirely on the 480-line screen.
  if (Y_BAR + H_BAR > 479) begin : g_bar_off_screen
    $error("paddle_ctrl: bar extends below the screen");
  end

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;
  typedef enum logic [1:0] {D_NONE, D_LEFT, D_RIGHT} dir_t;

  // Bit 0 = left button, bit 1 = right button throughout the input path.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [HW-1:0] hold_q, hold_d, hold_eff;
  dir_t          dir, dir_q;
  state_t        state_q, state_d;
  logic [9:0]    x_bar_q, x_bar_d;
  logic [9:0]    y_bar_q, y_bar_d;
  logic          start_q, start_rise;
  logic [10:0]   x_wide, step;

  // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  // Free-running move tick, one cycle wide on the wrap of the divider.
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Direction decode, hold acceleration, clamped motion and game FSM.
  always_comb begin
    start_rise = start & ~start_q;
    case (deb_q)
      2'b01:   dir = D_LEFT;
      2'b10:   dir = D_RIGHT;
      default: dir = D_NONE;
    endcase
    // A hold that just started or reversed uses the slow step on this very tick.
    hold_eff = (dir == D_NONE || dir != dir_q) ? '0 : hold_q;
    step     = (hold_eff < HW'(ACCEL_TICKS)) ? 11'(STEP_SLOW) : 11'(STEP_FAST);
    x_wide   = {1'b0, x_bar_q};
    hold_d   = hold_eff;
    state_d  = state_q;
    x_bar_d  = x_bar_q;
    y_bar_d  = 10'(Y_BAR);
    case (state_q)
      S_IDLE: begin
        x_bar_d = 10'(X_INIT);
        if (start_rise) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (endgame) begin
          state_d = S_OVER;
        end else if (tick && dir != D_NONE) begin
          if (hold_eff != HW'(ACCEL_TICKS)) hold_d = hold_eff + HW'(1);
          if (dir == D_LEFT)
            x_bar_d = (x_wide < LIM_LEFT + step) ? LIM_LEFT[9:0] : 10'(x_wide - step);
          else
            x_bar_d = (x_wide + step > LIM_RIGHT) ? LIM_RIGHT[9:0] : 10'(x_wide + step);
        end
      end
      S_OVER: begin
        if (start_rise) begin
          state_d = S_PLAY;
          x_bar_d = 10'(X_INIT);
          hold_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_cnt_q  <= '{default: '0};
      tick_cnt_q <= '0;
      hold_q     <= '0;
      dir_q      <= D_NONE;
      state_q    <= S_IDLE;
      x_bar_q    <= 10'(X_INIT);
      y_bar_q    <= 10'(Y_BAR);
      start_q    <= 1'b0;
    end else begin
      sync1_q    <= {btn_right, btn_left};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      dir_q      <= dir;
      state_q    <= state_d;
      x_bar_q    <= x_bar_d;
      y_bar_q    <= y_bar_d;
      start_q    <= start;
    end
  end

  assign x_bar   = x_bar_q;
  assign y_bar   = y_bar_q;
  assign playing = (state_q == S_PLAY);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with shortened tick/debounce/acceleration.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_left, btn_right, start, endgame;
  logic [9:0] x_bar, y_bar;
  logic       playing;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  paddle_ctrl #(
    .TICK_DIV   (4),
    .DEB_CYCLES (3),
    .ACCEL_TICKS(4)
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .start    (start),
    .endgame  (endgame),
    .x_bar    (x_bar),
    .y_bar    (y_bar),
    .playing  (playing)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Wait (bounded) for x_bar to move; a timeout shows up as a failed value check.
  task automatic wait_change(input int unsigned max_cyc);
    logic [9:0] prev;
    prev = x_bar;
    for (int unsigned i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (x_bar !== prev) break;
    end
  endtask

  task automatic expect_move(input string tag, input int unsigned exp);
    wait_change(20);
    check_eq(tag, 32'(x_bar), 32'(exp));
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned slow_r [6] = '{322, 324, 326, 328, 334, 340};
    int unsigned slow_l [4] = '{574, 572, 570, 568};
    int unsigned both_r [5] = '{66, 68, 70, 72, 78};

    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; start = 1'b0; endgame = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_x", 32'(x_bar), 320);
    check_eq("rst_y", 32'(y_bar), 440);
    check_eq("rst_playing", 32'(playing), 0);
    reset = 1'b0;

    // Buttons are ignored in IDLE.
    btn_left = 1'b1;
    idle_cycles(10);
    check_eq("idle_left_x", 32'(x_bar), 320);
    btn_left = 1'b0; btn_right = 1'b1;
    idle_cycles(10);
    check_eq("idle_right_x", 32'(x_bar), 320);
    check_eq("idle_playing", 32'(playing), 0);
    btn_right = 1'b0;
    idle_cycles(10);

    // Start and accelerate to the right.
    start = 1'b1;
    @(negedge clk);
    check_eq("start_playing", 32'(playing), 1);
    check_eq("start_x", 32'(x_bar), 320);
    start = 1'b0;
    btn_right = 1'b1;
    foreach (slow_r[i]) expect_move($sformatf("accel_r%0d", i), slow_r[i]);
    for (int unsigned k = 1; k <= 39; k++) expect_move($sformatf("fast_r%0d", k), 340 + 6 * k);
    expect_move("clamp_right", 576);
    idle_cycles(12);
    check_eq("hold_at_right", 32'(x_bar), 576);
    check_eq("hold_at_right_playing", 32'(playing), 1);

    // Reverse straight to the left and ride into the left limit.
    btn_right = 1'b0; btn_left = 1'b1;
    foreach (slow_l[i]) expect_move($sformatf("accel_l%0d", i), slow_l[i]);
    for (int unsigned k = 1; k <= 84; k++) expect_move($sformatf("fast_l%0d", k), 568 - 6 * k);
    idle_cycles(12);
    check_eq("hold_at_left", 32'(x_bar), 64);

    // Both held: no motion; dropping left restarts the hold with the slow step.
    btn_right = 1'b1;
    idle_cycles(20);
    check_eq("both_held", 32'(x_bar), 64);
    btn_left = 1'b0;
    foreach (both_r[i]) expect_move($sformatf("restart_r%0d", i), both_r[i]);

    // Endgame on the tick cycle: the tick after the last move is 4 edges later.
    repeat (3) @(posedge clk);
    @(negedge clk);
    endgame = 1'b1;
    @(negedge clk);
    check_eq("endgame_x", 32'(x_bar), 78);
    check_eq("endgame_playing", 32'(playing), 0);
    btn_right = 1'b0;
    idle_cycles(12);
    check_eq("over_frozen_x", 32'(x_bar), 78);
    check_eq("over_playing", 32'(playing), 0);

    // Restart from OVER while endgame is still high.
    start = 1'b1;
    @(negedge clk);
    check_eq("restart_x", 32'(x_bar), 320);
    check_eq("restart_playing", 32'(playing), 1);
    start = 1'b0; endgame = 1'b0;
    idle_cycles(12);
    check_eq("no_btn_x", 32'(x_bar), 320);
    check_eq("no_btn_playing", 32'(playing), 1);

    // Two-cycle glitch is rejected.
    btn_left = 1'b1;
    idle_cycles(2);
    btn_left = 1'b0;
    idle_cycles(16);
    check_eq("glitch_x", 32'(x_bar), 320);

    // Reset in the middle of a hold.
    btn_right = 1'b1;
    expect_move("pre_reset0", 322);
    expect_move("pre_reset1", 324);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midreset_x", 32'(x_bar), 320);
    check_eq("midreset_y", 32'(y_bar), 440);
    check_eq("midreset_playing", 32'(playing), 0);
    reset = 1'b0;
    idle_cycles(12);
    check_eq("post_reset_idle_x", 32'(x_bar), 320);
    check_eq("post_reset_playing", 32'(playing), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
